tt_reshape_seq: RTL and testbench
=================================

Name: tt_reshape_seq

Overview:
- Streaming transpose sequencer for the VPU.
- Collects up to X_WIDTH row beats, each Y_WIDTH bits wide, into an internal X_WIDTH x Y_WIDTH tile buffer.
- Then drains the tile as Y_WIDTH column beats, each X_WIDTH bits wide.
- Sits between a per-lane producer (e.g. mask/predicate generation) and a consumer that wants per-bit-plane vectors. It uses valid/ready handshakes on both sides.

Parameters:
- X_WIDTH, 32, rows per tile and width of each output column beat (>=2).
- Y_WIDTH, 4, width of each input row beat and number of column beats per tile (>=2).

Ports:
- i_clk  input  1  clock.
- i_reset_n  input  1  synchronous active-low reset.
- i_flush  input  1  synchronous abort: discards tile contents and returns to FILL.
- i_row_vld  input  1  input row beat valid.
- i_row_data  input  Y_WIDTH  input row beat; beat k lands in tile row k.
- i_row_last  input  1  qualifies i_row_vld; closes the tile early.
- o_row_rdy  output  1  sequencer can accept a row beat.
- o_col_vld  output  1  output column beat valid.
- o_col_data  output  X_WIDTH  column beat; bit x = tile[x][col_idx].
- o_col_last  output  1  qualifies o_col_vld; final column (col_idx==Y_WIDTH-1).
- i_col_rdy  input  1  consumer accepts column beat.
- o_busy  output  1  tile partially or fully loaded (wr_cnt!=0 or state==DRAIN).

Behaviour:
- Clock and reset: single clock i_clk. Reset is synchronous and active-low (i_reset_n), sampled on rising edge.
- Reset state: state=FILL, wr_cnt=0, col_idx=0, tile buffer all zeros.
- Outputs out of reset: o_row_rdy=1, o_col_vld=0, o_col_last=0, o_col_data=0, o_busy=0.
- Counter widths: wr_cnt is $clog2(X_WIDTH) bits, col_idx is $clog2(Y_WIDTH) bits, each minimum 1.
- States: FILL and DRAIN, registered.
- FILL:
  - o_row_rdy=1, o_col_vld=0.
  - Row handshake (i_row_vld & o_row_rdy): tile[wr_cnt] <= i_row_data.
  - If wr_cnt==X_WIDTH-1 or i_row_last: go to DRAIN and set wr_cnt<=0. Otherwise wr_cnt++.
  - Rows not written in a tile closed early remain zero.
- DRAIN:
  - o_row_rdy=0, o_col_vld=1.
  - o_col_data is a combinational transpose slice of the registered tile at col_idx.
  - o_col_last=(col_idx==Y_WIDTH-1).
  - Column handshake (o_col_vld & i_col_rdy): col_idx++.
  - On the last column: col_idx<=0, tile cleared to zero, state<=FILL.
- Latency:
  - The first column is valid the cycle after the closing row handshake.
  - Full tile throughput is X_WIDTH+Y_WIDTH cycles with no stalls. There is no overlap of fill and drain (single buffer).
- Backpressure: while o_col_vld=1 and i_col_rdy=0, o_col_data, o_col_last and col_idx hold stable.
- Producer side: row beats presented while o_row_rdy=0 are not consumed and the producer must hold them.
- i_flush:
  - Highest priority after reset. Any handshake in the same cycle is ignored.
  - Next cycle: state=FILL, wr_cnt=0, col_idx=0, tile zero, o_busy=0.
- Reset asserted mid-FILL or mid-DRAIN gives exactly the reset state next cycle. No partial column is emitted.
- i_row_last on row 0 closes a one-row tile. DRAIN still emits all Y_WIDTH columns.
- i_row_last on row X_WIDTH-1 behaves identically to the full-count close.
- o_col_data is 0 whenever o_col_vld=0.
- Simulation assertions under SIM, suppressed with DISABLE_ASSERTIONS=1:
  - i_row_vld held with stable data until accepted.
  - No X on o_col_vld or o_row_rdy after reset.

Test Plan:
- Defaults (X=32, Y=4). Feed rows x=0..31 with data=x[3:0], i_col_rdy=1.
  - Columns must be 0xAAAAAAAA, 0xCCCCCCCC, 0xF0F0F0F0, 0xFF00FF00.
  - o_col_last must be set on the 4th column only.
  - First o_col_vld must rise 1 cycle after row 31 is accepted.
- Early close: rows 0xF, 0x0, 0xF with i_row_last on the 3rd.
  - Four columns, each 0x00000005.
  - Next tile rows 0x1 x32 must give columns 0xFFFFFFFF, 0, 0, 0, with no residue.
- Backpressure: hold i_col_rdy=0 for 5 cycles at column 1 of the first-scenario tile.
  - o_col_vld=1 and o_col_data=0xCCCCCCCC stable throughout.
  - o_row_rdy=0 throughout; a row presented during this time is not consumed.
- Flush mid-drain: assert i_flush after 2 columns accepted.
  - Next cycle o_col_vld=0, o_row_rdy=1, o_busy=0.
  - A following 1-row tile of 0x8 must yield columns 0, 0, 0, 0x00000001.
- Reset mid-fill: drop i_reset_n after 10 rows for 1 cycle.
  - Outputs must match the reset values.
  - The following full tile must match the first scenario exactly.
- Simultaneous flush and row handshake in FILL: the row is dropped, wr_cnt=0 and o_busy=0 next cycle.

Source files
------------

// File: rtl/tt_reshape_seq.sv
// tt_reshape_seq: streaming transpose sequencer.
// Row beats fill a single X_WIDTH x Y_WIDTH tile, which is then drained as
// Y_WIDTH column beats, each X_WIDTH bits wide. Fill and drain never overlap.
module tt_reshape_seq #(
    parameter int X_WIDTH = 32,
    parameter int Y_WIDTH = 4
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic               i_flush,
    input  logic               i_row_vld,
    input  logic [Y_WIDTH-1:0] i_row_data,
    input  logic               i_row_last,
    output logic               o_row_rdy,
    output logic               o_col_vld,
    output logic [X_WIDTH-1:0] o_col_data,
    output logic               o_col_last,
    input  logic               i_col_rdy,
    output logic               o_busy
);

    localparam int WCW = (X_WIDTH > 1) ? $clog2(X_WIDTH) : 1;
    localparam int CIW = (Y_WIDTH > 1) ? $clog2(Y_WIDTH) : 1;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    state_e                           state_q, state_d;
    logic [WCW-1:0]                   wrCnt_q, wrCnt_d;
    logic [CIW-1:0]                   colIdx_q, colIdx_d;
    logic [X_WIDTH-1:0][Y_WIDTH-1:0]  tile_q, tile_d;
    logic [X_WIDTH-1:0]               colData;

    // Next-state logic: flush wins over any handshake, then fill or drain progress.
    always_comb begin
        state_d  = state_q;
        wrCnt_d  = wrCnt_q;
        colIdx_d = colIdx_q;
        tile_d   = tile_q;
        if (i_flush) begin
            state_d  = FILL;
            wrCnt_d  = '0;
            colIdx_d = '0;
            tile_d   = '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (i_row_vld) begin
                        tile_d[wrCnt_q] = i_row_data;
                        if ((wrCnt_q == WCW'(X_WIDTH - 1)) || i_row_last) begin
                            state_d = DRAIN;
                            wrCnt_d = '0;
                        end else begin
                            wrCnt_d = wrCnt_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (i_col_rdy) begin
                        if (colIdx_q == CIW'(Y_WIDTH - 1)) begin
                            colIdx_d = '0;
                            tile_d   = '0;
                            state_d  = FILL;
                        end else begin
                            colIdx_d = colIdx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = FILL;
                end
            endcase
        end
    end

    // State, counters and tile storage; a low reset restores the empty tile.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q  <= FILL;
            wrCnt_q  <= '0;
            colIdx_q <= '0;
            tile_q   <= '0;
        end else begin
            state_q  <= state_d;
            wrCnt_q  <= wrCnt_d;
            colIdx_q <= colIdx_d;
            tile_q   <= tile_d;
        end
    end

    // Transpose slice of the tile at the current column, forced to zero outside drain.
    always_comb begin
        colData = '0;
        if (state_q == DRAIN) begin
            for (int x = 0; x < X_WIDTH; x++) begin
                colData[x] = tile_q[x][colIdx_q];
            end
        end
    end

    assign o_row_rdy  = (state_q == FILL);
    assign o_col_vld  = (state_q == DRAIN);
    assign o_col_data = colData;
    assign o_col_last = (state_q == DRAIN) && (colIdx_q == CIW'(Y_WIDTH - 1));
    assign o_busy     = (wrCnt_q != '0) || (state_q == DRAIN);

`ifdef SIM
`ifndef DISABLE_ASSERTIONS
    // A stalled row beat must stay presented with unchanged data until accepted.
    rowHoldA: assert property (@(posedge i_clk) disable iff (!i_reset_n || i_flush)
        (i_row_vld && !o_row_rdy) |=> (i_row_vld && $stable(i_row_data)))
        else $error("row beat dropped or changed while stalled");

    // Handshake outputs must always be known once out of reset.
    noXA: assert property (@(posedge i_clk)
        i_reset_n |-> !$isunknown({o_col_vld, o_row_rdy}))
        else $error("X on o_col_vld or o_row_rdy");
`endif
`endif

endmodule

// File: tb/tb_tt_reshape_seq.sv
// tb_tt_reshape_seq: directed bench for tt_reshape_seq with a queue-based tile model.
module tb_tt_reshape_seq;

   localparam int X = 32;
   localparam int Y = 4;

   logic          clk     = 1'b0;
   logic          rstN    = 1'b0;
   logic          flush   = 1'b0;
   logic          rowVld  = 1'b0;
   logic [Y-1:0]  rowData = '0;
   logic          rowLast = 1'b0;
   logic          colRdy  = 1'b0;
   logic          rowRdy;
   logic          colVld;
   logic [X-1:0]  colData;
   logic          colLast;
   logic          busy;

   int testsRun    = 0;
   int testsFailed = 0;
   bit checkEn     = 1'b0;

   logic [Y-1:0]  mRows [X];
   int            mRowCnt = 0;
   logic [X-1:0]  mCols [$];

   logic [X-1:0]  capData [$];
   bit            capLast [$];

   tt_reshape_seq #(.X_WIDTH(X), .Y_WIDTH(Y)) dut (
      .i_clk      (clk),
      .i_reset_n  (rstN),
      .i_flush    (flush),
      .i_row_vld  (rowVld),
      .i_row_data (rowData),
      .i_row_last (rowLast),
      .o_row_rdy  (rowRdy),
      .o_col_vld  (colVld),
      .o_col_data (colData),
      .o_col_last (colLast),
      .i_col_rdy  (colRdy),
      .o_busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Model: collect rows into a list; once the tile closes, all columns are
   // computed at once and queued, then popped one per accepted column beat.
   always @(posedge clk) begin
      if (!rstN || flush) begin
         mRowCnt = 0;
         mCols.delete();
      end else if (mCols.size() == 0) begin
         if (rowVld) begin
            mRows[mRowCnt] = rowData;
            mRowCnt++;
            if (mRowCnt == X || rowLast) begin
               for (int c = 0; c < Y; c++) begin
                  logic [X-1:0] col;
                  col = '0;
                  for (int r = 0; r < mRowCnt; r++) col[r] = mRows[r][c];
                  mCols.push_back(col);
               end
               mRowCnt = 0;
            end
         end
      end else if (colRdy) begin
         mCols.delete(0);
      end
   end

   // Every cycle, compare the DUT against the model and log accepted columns.
   always @(negedge clk) begin
      if (checkEn) begin
         logic [X-1:0] expData;
         expData = (mCols.size() != 0) ? mCols[0] : '0;
         checkOutput("rowRdy",  64'(rowRdy),  64'(mCols.size() == 0));
         checkOutput("colVld",  64'(colVld),  64'(mCols.size() != 0));
         checkOutput("colData", 64'(colData), 64'(expData));
         checkOutput("colLast", 64'(colLast), 64'(mCols.size() == 1));
         checkOutput("busy",    64'(busy),    64'((mRowCnt != 0) || (mCols.size() != 0)));
         if (colVld && colRdy && !flush && rstN) begin
            capData.push_back(colData);
            capLast.push_back(colLast);
         end
      end
   end

   task automatic applyStimulus(input logic vld, input logic [Y-1:0] data, input logic last,
                                input logic cRdy, input logic fl, input logic rn);
      rowVld  = vld;
      rowData = data;
      rowLast = last;
      colRdy  = cRdy;
      flush   = fl;
      rstN    = rn;
      @(posedge clk);
      #1;
   endtask

   task automatic feedFull();
      for (int x = 0; x < X; x++) applyStimulus(1'b1, 4'(x), 1'b0, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic drainCols(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);
   endtask

   task automatic checkCapture(input string name, input logic [31:0] e0, input logic [31:0] e1,
                               input logic [31:0] e2, input logic [31:0] e3);
      logic [31:0] exp [4];
      exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
      checkOutput({name, "Count"}, 64'(capData.size()), 64'd4);
      if (capData.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("%sCol%0d", name, i), 64'(capData[i]), 64'(exp[i]));
            checkOutput($sformatf("%sLast%0d", name, i), 64'(capLast[i]), 64'(i == 3));
         end
      end
   endtask

   task automatic checkResetOutputs(input string name);
      checkOutput({name, "RowRdy"},  64'(rowRdy),  64'd1);
      checkOutput({name, "ColVld"},  64'(colVld),  64'd0);
      checkOutput({name, "ColLast"}, 64'(colLast), 64'd0);
      checkOutput({name, "ColData"}, 64'(colData), 64'd0);
      checkOutput({name, "Busy"},    64'(busy),    64'd0);
   endtask

   initial begin
      // Reset
      applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkEn = 1'b1;
      checkResetOutputs("reset");
      applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);

      // Full tile with data = row index
      capData.delete(); capLast.delete();
      feedFull();
      checkOutput("firstColLatency", 64'(colVld), 64'd1);
      drainCols(4);
      checkCapture("fullTile", 32'hAAAAAAAA, 32'hCCCCCCCC, 32'hF0F0F0F0, 32'hFF00FF00);
      checkOutput("fullTileBackToFill", 64'(rowRdy), 64'd1);

      // Early close after three rows, then a fresh tile must carry no residue
      capData.delete(); capLast.delete();
      applyStimulus(1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 4'h0, 1'b0, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 4'hF, 1'b1, 1'b1, 1'b0, 1'b1);
      drainCols(4);
      checkCapture("earlyClose", 32'h5, 32'h5, 32'h5, 32'h5);
      capData.delete(); capLast.delete();
      for (int x = 0; x < X; x++) applyStimulus(1'b1, 4'h1, 1'b0, 1'b1, 1'b0, 1'b1);
      drainCols(4);
      checkCapture("noResidue", 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0);

      // Backpressure at column 1 with a row beat held by the producer
      capData.delete(); capLast.delete();
      feedFull();
      drainCols(1);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 4'h7, 1'b1, 1'b0, 1'b0, 1'b1);
         checkOutput("bpColVld",  64'(colVld),  64'd1);
         checkOutput("bpColData", 64'(colData), 64'hCCCCCCCC);
         checkOutput("bpRowRdy",  64'(rowRdy),  64'd0);
      end
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'h7, 1'b1, 1'b1, 1'b0, 1'b1);
      checkCapture("bpTile", 32'hAAAAAAAA, 32'hCCCCCCCC, 32'hF0F0F0F0, 32'hFF00FF00);
      capData.delete(); capLast.delete();
      drainCols(4);
      checkCapture("heldRow", 32'h1, 32'h1, 32'h1, 32'h0);

      // Flush after two columns accepted
      capData.delete(); capLast.delete();
      feedFull();
      drainCols(2);
      applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 1'b1);
      checkOutput("flushColVld",  64'(colVld),  64'd0);
      checkOutput("flushRowRdy",  64'(rowRdy),  64'd1);
      checkOutput("flushBusy",    64'(busy),    64'd0);
      checkOutput("flushColData", 64'(colData), 64'd0);
      checkOutput("flushColsSeen", 64'(capData.size()), 64'd2);
      capData.delete(); capLast.delete();
      applyStimulus(1'b1, 4'h8, 1'b1, 1'b1, 1'b0, 1'b1);
      drainCols(4);
      checkCapture("afterFlush", 32'h0, 32'h0, 32'h0, 32'h1);

      // Reset in the middle of a fill
      for (int x = 0; x < 10; x++) applyStimulus(1'b1, 4'(x), 1'b0, 1'b1, 1'b0, 1'b1);
      checkOutput("midFillBusy", 64'(busy), 64'd1);
      applyStimulus(1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0);
      checkResetOutputs("midFillReset");
      capData.delete(); capLast.delete();
      feedFull();
      drainCols(4);
      checkCapture("afterReset", 32'hAAAAAAAA, 32'hCCCCCCCC, 32'hF0F0F0F0, 32'hFF00FF00);

      // Flush coinciding with a row handshake in fill
      for (int x = 0; x < 5; x++) applyStimulus(1'b1, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b1, 4'hF, 1'b0, 1'b1, 1'b1, 1'b1);
      checkOutput("flushRowBusy",   64'(busy),   64'd0);
      checkOutput("flushRowRowRdy", 64'(rowRdy), 64'd1);
      capData.delete(); capLast.delete();
      applyStimulus(1'b1, 4'h3, 1'b1, 1'b1, 1'b0, 1'b1);
      drainCols(4);
      checkCapture("afterFlushRow", 32'h1, 32'h1, 32'h0, 32'h0);

      drainCols(3);
      checkEn = 1'b0;
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
